// File: rtl/ysyx_22041071_axi_rd_slave_pkg.sv
// Shared AXI encodings and widths for the AXI read-slave slice.
// Imported by the burst address helper and the read-slave top.
package ysyx_22041071_axi_rd_slave_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // An unsupported burst/size poisons the whole burst, so it outranks a range miss.
  function automatic resp_e beat_resp(input logic burst_err, input logic in_range);
    if (burst_err)      return RESP_SLVERR;
    else if (!in_range) return RESP_DECERR;
    else                return RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22041071_axi_burst_addr.sv
// Combinational beat-address helper: next burst address, range check,
// memory word index and burst/size legality for the current beat.
module ysyx_22041071_axi_burst_addr
  import ysyx_22041071_axi_rd_slave_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int                MEM_WORDS = 65536,
  localparam int               IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]      next_addr,
  output logic                   in_range,
  output logic [IDX_W-1:0]       word_idx,
  output logic                   burst_err
);

  localparam int                BYTE_LSB  = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS) << BYTE_LSB;

  logic [ADDR_W-1:0] offset;

  // NOTE: every output gets a value on every path, so no latch can be inferred.
  always_comb begin
    offset    = addr - BASE_ADDR;
    in_range  = (addr >= BASE_ADDR) && (offset < MEM_BYTES);
    word_idx  = offset[BYTE_LSB +: IDX_W];
    burst_err = !(burst inside {BURST_FIXED, BURST_INCR}) ||
                (size > AXI_SIZE_W'(BYTE_LSB));
    // Full unaligned address advances; modulo wrap at ADDR_W is intended.
    next_addr = (burst == BURST_INCR) ? addr + (ADDR_W'(1) << size) : addr;
  end

endmodule

// File: rtl/ysyx_22041071_axi_rd_slave.sv
// AXI4 read-channel responder (AR in, R out) in front of a word-wide
// synchronous memory with one cycle of read latency.
module ysyx_22041071_axi_rd_slave
  import ysyx_22041071_axi_rd_slave_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 64,
  parameter int                ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int                MEM_WORDS = 65536,
  localparam int               IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   axi_ar_valid_i,
  output logic                   axi_ar_ready_o,
  input  logic [ID_W-1:0]        axi_ar_id_i,
  input  logic [ADDR_W-1:0]      axi_ar_addr_i,
  input  logic [AXI_LEN_W-1:0]   axi_ar_len_i,
  input  logic [AXI_SIZE_W-1:0]  axi_ar_size_i,
  input  logic [AXI_BURST_W-1:0] axi_ar_burst_i,
  output logic                   axi_r_valid_o,
  input  logic                   axi_r_ready_i,
  output logic [ID_W-1:0]        axi_r_id_o,
  output logic [DATA_W-1:0]      axi_r_data_o,
  output logic [AXI_RESP_W-1:0]  axi_r_resp_o,
  output logic                   axi_r_last_o,
  output logic                   axi_r_user_o,
  output logic                   mem_en_o,
  output logic [IDX_W-1:0]       mem_addr_o,
  input  logic [DATA_W-1:0]      mem_rdata_i
);

  state_e                 state, next_state;
  logic                   ar_ready_q, r_valid_q, r_last_q;
  resp_e                  r_resp_q;
  logic [ID_W-1:0]        id_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [AXI_LEN_W-1:0]   len_q, beat_cnt;
  logic [AXI_SIZE_W-1:0]  size_q;
  logic [AXI_BURST_W-1:0] burst_q;
  logic                   rd_ok_q, held_q;
  logic [DATA_W-1:0]      r_data_q, beat_data;

  logic [ADDR_W-1:0]      next_addr;
  logic                   in_range, burst_err;
  logic                   ar_hs, r_hs;

  ysyx_22041071_axi_burst_addr #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .MEM_WORDS(MEM_WORDS)
  ) u_burst_addr (
    .addr     (addr_q),
    .size     (size_q),
    .burst    (burst_q),
    .next_addr(next_addr),
    .in_range (in_range),
    .word_idx (mem_addr_o),
    .burst_err(burst_err)
  );

  assign ar_hs = axi_ar_valid_i && ar_ready_q;
  assign r_hs  = r_valid_q && axi_r_ready_i;

  always_comb begin
    next_state = state;
    mem_en_o   = 1'b0;
    case (state)
      ST_IDLE: if (ar_hs) next_state = ST_MEM;
      ST_MEM: begin
        mem_en_o   = in_range && !burst_err;
        next_state = ST_RESP;
      end
      ST_RESP: if (r_hs) next_state = r_last_q ? ST_IDLE : ST_MEM;
      default: next_state = ST_IDLE;
    endcase
  end

  // Memory data is only valid in the first RESP cycle; a stalled beat replays the captured copy.
  assign beat_data = rd_ok_q ? mem_rdata_i : '0;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only control/output registers need reset; the AR payload is overwritten before use,
      // but it is cheap here and keeps r_id at 0 out of reset.
      state      <= ST_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      rd_ok_q    <= 1'b0;
      held_q     <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= next_state;
      ar_ready_q <= (next_state == ST_IDLE);
      r_valid_q  <= (next_state == ST_RESP);

      if (ar_hs) begin
        id_q     <= axi_ar_id_i;
        addr_q   <= axi_ar_addr_i;
        len_q    <= axi_ar_len_i;
        size_q   <= axi_ar_size_i;
        burst_q  <= axi_ar_burst_i;
        beat_cnt <= '0;
      end

      if (state == ST_MEM) begin
        r_resp_q <= beat_resp(burst_err, in_range);
        r_last_q <= (beat_cnt == len_q);
        rd_ok_q  <= mem_en_o;
        held_q   <= 1'b0;
      end

      if (state == ST_RESP) begin
        if (r_hs) begin
          if (!r_last_q) begin
            addr_q   <= next_addr;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end else if (!held_q) begin
          r_data_q <= beat_data;
          held_q   <= 1'b1;
        end
      end
    end
  end

  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_id_o     = id_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_last_o   = r_last_q;
  assign axi_r_user_o   = 1'b0;
  assign axi_r_data_o   = !r_valid_q ? '0 : (held_q ? r_data_q : beat_data);

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_slave.sv
// Directed bench for the AXI read slave: single-beat vector table plus
// hand-written burst, stall, boundary, error and mid-burst reset sequences.
module tb_ysyx_22041071_axi_rd_slave;
  import ysyx_22041071_axi_rd_slave_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last, r_user;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int mem_en_cnt = 0;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_slave dut (
    .clk           (clk),
    .reset         (reset),
    .axi_ar_valid_i(ar_valid),
    .axi_ar_ready_o(ar_ready),
    .axi_ar_id_i   (ar_id),
    .axi_ar_addr_i (ar_addr),
    .axi_ar_len_i  (ar_len),
    .axi_ar_size_i (ar_size),
    .axi_ar_burst_i(ar_burst),
    .axi_r_valid_o (r_valid),
    .axi_r_ready_i (r_ready),
    .axi_r_id_o    (r_id),
    .axi_r_data_o  (r_data),
    .axi_r_resp_o  (r_resp),
    .axi_r_last_o  (r_last),
    .axi_r_user_o  (r_user),
    .mem_en_o      (mem_en),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata)
  );

  function automatic logic [63:0] mem_word(input logic [15:0] idx);
    if (idx == 16'd1) return 64'hDEAD_BEEF_0123_4567;
    return {16'hC0DE, idx, ~idx, idx ^ 16'h5A00};
  endfunction

  // Memory model: data valid only in the cycle after a strobe, junk otherwise.
  logic        rd_valid = 1'b0;
  logic [63:0] rd_word  = '0;
  always @(posedge clk) begin
    rd_valid <= (mem_en === 1'b1);
    if (mem_en === 1'b1) begin
      rd_word    <= mem_word(mem_addr);
      mem_en_cnt <= mem_en_cnt + 1;
    end
  end
  assign mem_rdata = rd_valid ? rd_word : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
    while (ar_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (ar_ready !== 1'b1) begin
      check("ar_ready_timeout", {63'd0, ar_ready}, 64'd1);
      ar_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ar_valid = 1'b0;
  endtask

  // Waits for r_valid, samples the beat, holds r_ready low for 'stall' cycles, then handshakes.
  task automatic get_beat(input int stall, output logic [63:0] data, output logic [1:0] resp,
                          output logic last, output logic [3:0] id, output logic stable,
                          output int waited);
    int n = 0;
    @(negedge clk);
    while (r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    waited = n;
    if (r_valid !== 1'b1) begin
      check("r_valid_timeout", {63'd0, r_valid}, 64'd1);
      data = '0; resp = '0; last = 1'b0; id = '0; stable = 1'b0;
      return;
    end
    data = r_data; resp = r_resp; last = r_last; id = r_id; stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (r_valid !== 1'b1 || r_data !== data || r_resp !== resp || r_last !== last) stable = 1'b0;
    end
    r_ready = 1'b1;
    @(posedge clk);
    #1 r_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    int          reads;
  } vec_t;

  vec_t vecs[9];

  logic [63:0] d;
  logic [1:0]  rs;
  logic        lst, stb;
  logic [3:0]  rid;
  int          wt, base_cnt, seen;

  initial begin
    vecs[0] = '{BASE + 64'h10,     3'd3, BURST_INCR,  4'd1,  mem_word(16'd2),     RESP_OKAY,   1};
    vecs[1] = '{BASE + 64'h18,     3'd3, BURST_FIXED, 4'd2,  mem_word(16'd3),     RESP_OKAY,   1};
    vecs[2] = '{BASE - 64'h8,      3'd3, BURST_INCR,  4'd3,  64'd0,               RESP_DECERR, 0};
    vecs[3] = '{64'h8008_0000,     3'd3, BURST_INCR,  4'd4,  64'd0,               RESP_DECERR, 0};
    vecs[4] = '{BASE + 64'h20,     3'd4, BURST_INCR,  4'd6,  64'd0,               RESP_SLVERR, 0};
    vecs[5] = '{BASE + 64'h20,     3'd3, BURST_RSVD,  4'd8,  64'd0,               RESP_SLVERR, 0};
    vecs[6] = '{64'h7000_0000,     3'd3, BURST_WRAP,  4'd9,  64'd0,               RESP_SLVERR, 0};
    vecs[7] = '{64'h8007_FFFF,     3'd0, BURST_INCR,  4'd15, mem_word(16'hFFFF),  RESP_OKAY,   1};
    vecs[8] = '{64'h1_8000_0000,   3'd3, BURST_INCR,  4'd10, 64'd0,               RESP_DECERR, 0};

    reset = 1'b1; ar_valid = 1'b0; r_ready = 1'b0;
    ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_id = '0;
    repeat (3) @(negedge clk);
    check("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
    check("rst_r_valid",  {63'd0, r_valid},  64'd0);
    check("rst_r_last",   {63'd0, r_last},   64'd0);
    check("rst_r_data",   r_data,            64'd0);
    check("rst_r_resp",   {62'd0, r_resp},   64'd0);
    check("rst_r_id",     {60'd0, r_id},     64'd0);
    check("rst_mem_en",   {63'd0, mem_en},   64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ar_ready", {63'd0, ar_ready}, 64'd1);

    // Test 1: single beat, 2-cycle latency.
    send_ar(BASE + 64'h8, 8'd0, 3'd3, BURST_INCR, 4'd5);
    get_beat(0, d, rs, lst, rid, stb, wt);
    check("t1_latency", 64'(wt), 64'd1);
    check("t1_data", d, 64'hDEAD_BEEF_0123_4567);
    check("t1_resp", {62'd0, rs}, 64'd0);
    check("t1_last", {63'd0, lst}, 64'd1);
    check("t1_id", {60'd0, rid}, 64'd5);
    check("t1_user", {63'd0, r_user}, 64'd0);

    // Single-beat vector table.
    foreach (vecs[k]) begin
      base_cnt = mem_en_cnt;
      send_ar(vecs[k].addr, 8'd0, vecs[k].size, vecs[k].burst, vecs[k].id);
      get_beat(1, d, rs, lst, rid, stb, wt);
      check($sformatf("vec%0d_data", k), d, vecs[k].data);
      check($sformatf("vec%0d_resp", k), {62'd0, rs}, {62'd0, vecs[k].resp});
      check($sformatf("vec%0d_last", k), {63'd0, lst}, 64'd1);
      check($sformatf("vec%0d_id", k), {60'd0, rid}, {60'd0, vecs[k].id});
      check($sformatf("vec%0d_reads", k), 64'(mem_en_cnt - base_cnt), 64'(vecs[k].reads));
    end

    // Test 2: 4-beat INCR with r_ready stalls; data must hold while stalled.
    send_ar(BASE, 8'd3, 3'd3, BURST_INCR, 4'd2);
    for (int b = 0; b < 4; b++) begin
      int st;
      st = (b % 2 == 1) ? 2 : 0;
      get_beat(st, d, rs, lst, rid, stb, wt);
      check($sformatf("t2_b%0d_data", b), d, mem_word(16'(b)));
      check($sformatf("t2_b%0d_stable", b), {63'd0, stb}, 64'd1);
      check($sformatf("t2_b%0d_last", b), {63'd0, lst}, (b == 3) ? 64'd1 : 64'd0);
      check($sformatf("t2_b%0d_gap", b), 64'(wt), 64'd1);
    end

    // Test 3: byte-sized INCR from an unaligned address crosses into word 1 on beat 6.
    send_ar(BASE + 64'h3, 8'd5, 3'd0, BURST_INCR, 4'd3);
    for (int b = 0; b < 6; b++) begin
      get_beat(0, d, rs, lst, rid, stb, wt);
      check($sformatf("t3_b%0d_data", b), d, mem_word((b == 5) ? 16'd1 : 16'd0));
      check($sformatf("t3_b%0d_resp", b), {62'd0, rs}, 64'd0);
    end

    // FIXED burst keeps the same word.
    send_ar(BASE + 64'h28, 8'd2, 3'd3, BURST_FIXED, 4'd4);
    for (int b = 0; b < 3; b++) begin
      get_beat(0, d, rs, lst, rid, stb, wt);
      check($sformatf("fix_b%0d_data", b), d, mem_word(16'd5));
    end

    // Test 4: last word then off the end.
    base_cnt = mem_en_cnt;
    send_ar(64'h8007_FFF8, 8'd1, 3'd3, BURST_INCR, 4'd6);
    get_beat(0, d, rs, lst, rid, stb, wt);
    check("t4_b0_data", d, mem_word(16'hFFFF));
    check("t4_b0_resp", {62'd0, rs}, 64'd0);
    get_beat(0, d, rs, lst, rid, stb, wt);
    check("t4_b1_data", d, 64'd0);
    check("t4_b1_resp", {62'd0, rs}, 64'd3);
    check("t4_b1_last", {63'd0, lst}, 64'd1);
    check("t4_reads", 64'(mem_en_cnt - base_cnt), 64'd1);

    // Test 5: WRAP burst -> SLVERR on every beat, no memory reads.
    base_cnt = mem_en_cnt;
    send_ar(BASE, 8'd2, 3'd3, BURST_WRAP, 4'd7);
    for (int b = 0; b < 3; b++) begin
      get_beat(0, d, rs, lst, rid, stb, wt);
      check($sformatf("t5_b%0d_resp", b), {62'd0, rs}, 64'd2);
      check($sformatf("t5_b%0d_data", b), d, 64'd0);
      check($sformatf("t5_b%0d_last", b), {63'd0, lst}, (b == 2) ? 64'd1 : 64'd0);
    end
    check("t5_reads", 64'(mem_en_cnt - base_cnt), 64'd0);

    // Test 6: reset while beat 2 of 4 is waiting for r_ready.
    send_ar(BASE, 8'd3, 3'd3, BURST_INCR, 4'd9);
    get_beat(0, d, rs, lst, rid, stb, wt);
    check("t6_b0_data", d, mem_word(16'd0));
    wt = 0;
    @(negedge clk);
    while (r_valid !== 1'b1 && wt < 20) begin @(negedge clk); wt++; end
    check("t6_b1_valid", {63'd0, r_valid}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("t6_rst_ar_ready", {63'd0, ar_ready}, 64'd0);
    reset = 1'b0;
    r_ready = 1'b1;
    seen = 0;
    base_cnt = mem_en_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (r_valid === 1'b1) seen++;
    end
    r_ready = 1'b0;
    check("t6_no_beats", 64'(seen), 64'd0);
    check("t6_no_reads", 64'(mem_en_cnt - base_cnt), 64'd0);
    check("t6_ar_ready", {63'd0, ar_ready}, 64'd1);
    send_ar(BASE + 64'h8, 8'd0, 3'd3, BURST_INCR, 4'd5);
    get_beat(0, d, rs, lst, rid, stb, wt);
    check("t6_new_data", d, 64'hDEAD_BEEF_0123_4567);
    check("t6_new_id", {60'd0, rid}, 64'd5);
    check("t6_new_last", {63'd0, lst}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
